// File: rtl/tt_um_hoene_protocol_frame.sv
// ============================================================================
// Module   : tt_um_hoene_protocol_frame
// Brief    : Serial frame decoder: length byte, payload bytes and XOR checksum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tt_um_hoene_protocol_frame #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_insync,
    input  logic       in_data,
    input  logic       in_clk,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [7:0] frame_len,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_error,
    output logic       busy
);

    localparam logic [7:0] C_MAX_LEN = MAX_LEN[7:0];

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state, w_state;
    logic [2:0] r_bit_cnt, w_bit_cnt;
    logic [7:0] r_byte_cnt, w_byte_cnt;
    // Only the low seven bits of the shift register ever feed a completed byte.
    logic [6:0] r_shift, w_shift;
    logic [7:0] r_xor, w_xor;
    logic       r_armed, w_armed;
    logic [7:0] r_byte_data, w_byte_data;
    logic [7:0] r_frame_len, w_frame_len;
    logic       r_byte_valid, w_byte_valid;
    logic       r_frame_start, w_frame_start;
    logic       r_frame_end, w_frame_end;
    logic       r_frame_error, w_frame_error;
    logic       r_busy, w_busy;

    logic [7:0] w_byte;
    logic       w_last_bit;
    logic       w_in_frame;

    assign w_byte     = {r_shift, in_data};
    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_byte_cnt    <= 8'd0;
            r_shift       <= 7'd0;
            r_xor         <= 8'd0;
            r_armed       <= 1'b0;
            r_byte_data   <= 8'd0;
            r_frame_len   <= 8'd0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_error <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_bit_cnt     <= w_bit_cnt;
            r_byte_cnt    <= w_byte_cnt;
            r_shift       <= w_shift;
            r_xor         <= w_xor;
            r_armed       <= w_armed;
            r_byte_data   <= w_byte_data;
            r_frame_len   <= w_frame_len;
            r_byte_valid  <= w_byte_valid;
            r_frame_start <= w_frame_start;
            r_frame_end   <= w_frame_end;
            r_frame_error <= w_frame_error;
            r_busy        <= w_busy;
        end
    end

    always_comb begin
        w_state       = r_state;
        w_bit_cnt     = r_bit_cnt;
        w_byte_cnt    = r_byte_cnt;
        w_shift       = r_shift;
        w_xor         = r_xor;
        w_armed       = r_armed;
        w_byte_data   = r_byte_data;
        w_frame_len   = r_frame_len;
        w_byte_valid  = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_frame_error = 1'b0;

        if (!in_insync) begin
            // A low sync flag also arms IDLE, so a frame always needs a fresh sync rise.
            w_state       = S_IDLE;
            w_bit_cnt     = 3'd0;
            w_armed       = 1'b1;
            w_frame_error = w_in_frame;
        end else if (in_clk) begin
            case (r_state)
                S_IDLE: begin
                    if (r_armed) begin
                        w_state = S_LEN;
                        w_armed = 1'b0;
                    end
                end
                S_LEN, S_PAYLOAD, S_CHECK: begin
                    w_shift   = w_byte[6:0];
                    w_bit_cnt = r_bit_cnt + 3'd1;
                    if (w_last_bit) begin
                        if (r_state == S_LEN) begin
                            if ((w_byte == 8'd0) || (w_byte > C_MAX_LEN)) begin
                                w_frame_error = 1'b1;
                                w_state       = S_DONE;
                            end else begin
                                w_frame_len   = w_byte;
                                w_frame_start = 1'b1;
                                w_byte_cnt    = w_byte;
                                w_xor         = 8'd0;
                                w_state       = S_PAYLOAD;
                            end
                        end else if (r_state == S_PAYLOAD) begin
                            w_byte_data  = w_byte;
                            w_byte_valid = 1'b1;
                            w_xor        = r_xor ^ w_byte;
                            w_byte_cnt   = r_byte_cnt - 8'd1;
                            if (r_byte_cnt == 8'd1) begin
                                w_state = S_CHECK;
                            end
                        end else begin
                            w_frame_end   = (w_byte == r_xor);
                            w_frame_error = (w_byte != r_xor);
                            w_state       = S_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end

        w_busy = (w_state == S_LEN) || (w_state == S_PAYLOAD) || (w_state == S_CHECK);
    end

    assign byte_data   = r_byte_data;
    assign byte_valid  = r_byte_valid;
    assign frame_len   = r_frame_len;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign frame_error = r_frame_error;
    assign busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tt_um_hoene_protocol_frame.sv
// ============================================================================
// Module   : tb_tt_um_hoene_protocol_frame
// Brief    : Directed scoreboard bench for the serial frame decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tt_um_hoene_protocol_frame;

    localparam int MAX_LEN = 64;
    localparam logic [1:0] K_START = 2'd0;
    localparam logic [1:0] K_VALID = 2'd1;
    localparam logic [1:0] K_END   = 2'd2;
    localparam logic [1:0] K_ERR   = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_insync = 1'b0;
    logic       in_data = 1'b0;
    logic       in_clk = 1'b0;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic [7:0] frame_len;
    logic       frame_start;
    logic       frame_end;
    logic       frame_error;
    logic       busy;
    logic       any_pulse;

    int  vectors = 0;
    int  miscompares = 0;
    int  gap = 1;
    int  n_pulses;
    ev_t obs_ev;
    ev_t sb[$];

    tt_um_hoene_protocol_frame #(.MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_insync   (in_insync),
        .in_data     (in_data),
        .in_clk      (in_clk),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .frame_len   (frame_len),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    assign any_pulse = frame_start | byte_valid | frame_end | frame_error;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every pulse is matched in order against the expected-event queue.
    always @(negedge clk) begin
        if (rst_n) begin
            n_pulses = int'(frame_start) + int'(byte_valid) + int'(frame_end) + int'(frame_error);
            if (n_pulses > 1) check("pulse_onehot", n_pulses, 1);
            if (n_pulses >= 1) begin
                obs_ev = frame_start ? {K_START, frame_len} :
                         byte_valid  ? {K_VALID, byte_data} :
                         frame_end   ? {K_END, 8'h00} : {K_ERR, 8'h00};
                if (sb.size() == 0) check("unexpected_pulse", {22'd0, obs_ev}, 32'hFFFF_FFFF);
                else check("scoreboard", {22'd0, obs_ev}, {22'd0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b);
        in_clk  = 1'b1;
        in_data = b;
        tick();
        if (gap != 0) begin
            in_clk = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input logic pulse, input string tag);
        for (int i = 7; i >= 0; i--) begin
            in_clk  = 1'b1;
            in_data = v[i];
            tick();
            if (i == 0) check({tag, "_latency"}, any_pulse, pulse);
            if (gap != 0) begin
                in_clk = 1'b0;
                repeat (gap) tick();
            end
        end
    endtask

    task automatic start_frame();
        in_insync = 1'b1;
        tick();
        strobe(1'b1);
    endtask

    task automatic drop_sync();
        in_clk    = 1'b0;
        in_insync = 1'b0;
        tick();
    endtask

    task automatic push(input logic [1:0] k, input logic [7:0] d);
        sb.push_back({k, d});
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {11'd0, byte_data, byte_valid, frame_len, frame_start,
              frame_end, frame_error, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Good frame: L=2, A5 3C, checksum 99
        start_frame();
        check("busy_len", busy, 1'b1);
        push(K_START, 8'h02); send_byte(8'h02, 1'b1, "good_len");
        push(K_VALID, 8'hA5); send_byte(8'hA5, 1'b1, "good_b0");
        push(K_VALID, 8'h3C); send_byte(8'h3C, 1'b1, "good_b1");
        push(K_END, 8'h00);   send_byte(8'h99, 1'b1, "good_chk");
        check("busy_done", busy, 1'b0);
        check("frame_len_held", frame_len, 8'h02);
        check("byte_data_held", byte_data, 8'h3C);
        send_byte(8'hFF, 1'b0, "done_ignore");
        drop_sync();

        // Bad checksum
        start_frame();
        push(K_START, 8'h02); send_byte(8'h02, 1'b1, "bad_len");
        push(K_VALID, 8'hA5); send_byte(8'hA5, 1'b1, "bad_b0");
        push(K_VALID, 8'h3C); send_byte(8'h3C, 1'b1, "bad_b1");
        push(K_ERR, 8'h00);   send_byte(8'h98, 1'b1, "bad_chk");
        send_byte(8'h55, 1'b0, "bad_done_ignore");
        check("bad_busy", busy, 1'b0);
        drop_sync();

        // Length out of range
        start_frame();
        push(K_ERR, 8'h00); send_byte(8'h00, 1'b1, "len_zero");
        drop_sync();
        start_frame();
        push(K_ERR, 8'h00); send_byte(8'(MAX_LEN + 1), 1'b1, "len_over");
        drop_sync();
        check("len_reject_keeps_len", frame_len, 8'h02);

        // Sync loss inside 2nd payload byte, then recovery
        start_frame();
        push(K_START, 8'h02); send_byte(8'h02, 1'b1, "loss_len");
        push(K_VALID, 8'hA5); send_byte(8'hA5, 1'b1, "loss_b0");
        strobe(1'b0); strobe(1'b0); strobe(1'b1);
        push(K_ERR, 8'h00);
        drop_sync();
        check("loss_err", frame_error, 1'b1);
        check("loss_busy", busy, 1'b0);
        start_frame();
        push(K_START, 8'h01); send_byte(8'h01, 1'b1, "resync_len");
        push(K_VALID, 8'h5A); send_byte(8'h5A, 1'b1, "resync_b0");
        push(K_END, 8'h00);   send_byte(8'h5A, 1'b1, "resync_chk");
        drop_sync();

        // Reset mid-payload; no decode until a new sync rise
        start_frame();
        push(K_START, 8'h03); send_byte(8'h03, 1'b1, "rst_len");
        push(K_VALID, 8'h11); send_byte(8'h11, 1'b1, "rst_b0");
        strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b0);
        rst_n = 1'b0;
        tick();
        check("rst_mid_outputs", {11'd0, byte_data, byte_valid, frame_len, frame_start,
              frame_end, frame_error, busy}, 32'd0);
        rst_n = 1'b1;
        strobe(1'b1);
        send_byte(8'h01, 1'b0, "rst_unarmed");
        check("rst_unarmed_busy", busy, 1'b0);
        drop_sync();

        // Back-to-back strobes, L=1 payload FF
        gap = 0;
        start_frame();
        push(K_START, 8'h01); send_byte(8'h01, 1'b1, "b2b_len");
        push(K_VALID, 8'hFF); send_byte(8'hFF, 1'b1, "b2b_b0");
        push(K_END, 8'h00);   send_byte(8'hFF, 1'b1, "b2b_chk");
        in_clk = 1'b0;
        gap = 1;
        tick();
        check("b2b_byte_data", byte_data, 8'hFF);
        drop_sync();

        repeat (3) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tt_um_hoene_protocol_frame.md
TT_UM_HOENE_PROTOCOL_FRAME -- requirements
Module: tt_um_hoene_protocol_frame

Interface
REQ-001 Parameter: MAX_LEN, 64, largest accepted payload length in bytes (1..255).
REQ-002 clk  input  1  global clock; all state changes on rising edge.
REQ-003 rst_n  input  1  device reset; synchronous, active-low.
REQ-004 in_insync  input  1  upstream sync flag; high while bitstream is in frame.
REQ-005 in_data  input  1  serial data bit, valid when in_clk=1.
REQ-006 in_clk  input  1  one-cycle bit strobe from the upstream sync stage.
REQ-007 byte_data  output  8  last completed payload byte, held until next payload byte.
REQ-008 byte_valid  output  1  one-cycle pulse per payload byte.
REQ-009 frame_len  output  8  accepted length byte, held until next frame's length byte.
REQ-010 frame_start  output  1  one-cycle pulse when a valid length byte is accepted.
REQ-011 frame_end  output  1  one-cycle pulse when the checksum matches.
REQ-012 frame_error  output  1  one-cycle pulse on any frame error.
REQ-013 busy  output  1  high in states LEN, PAYLOAD, CHECK.

Function
REQ-014 Frame format SHALL be: length byte L, then L payload bytes, then checksum byte = XOR of all payload bytes (initial 0x00); all bytes MSB first.
REQ-015 A bit SHALL be consumed only on a cycle with in_clk=1 and in_insync=1; shift register <= {shift[6:0], in_data}; 3-bit bit counter wraps 7->0.
REQ-016 State machine SHALL have states IDLE, LEN, PAYLOAD, CHECK, DONE.
REQ-017 IDLE: first consumed bit is the terminating sync bit; SHALL be discarded, bit counter stays 0, go to LEN.
REQ-018 LEN, 8th bit: L=0 or L>MAX_LEN -> frame_error pulse, go DONE; else frame_len<=L, frame_start pulse, byte counter<=L, XOR<=0x00, go PAYLOAD.
REQ-019 PAYLOAD, 8th bit: byte_data<=byte, byte_valid pulse, XOR^=byte, byte counter decrements; at counter 1->0 go CHECK.
REQ-020 CHECK, 8th bit: byte==XOR -> frame_end pulse, else frame_error pulse; go DONE in both cases.
REQ-021 DONE: all strobes ignored; SHALL stay until in_insync=0.
REQ-022 All outputs registered: pulses assert in the cycle after the edge sampling the completing 8th bit (latency 1 clk from that strobe); pulses last exactly one cycle.
REQ-023 in_insync=0 in any state SHALL force IDLE and clear bit counter next edge; if state was LEN, PAYLOAD or CHECK, frame_error pulses once.
REQ-024 in_insync=0 together with in_clk=1: loss of sync dominates, bit is not consumed.
REQ-025 frame_start, byte_valid, frame_end, frame_error SHALL never assert in the same cycle except as stated (at most one per cycle by construction).
REQ-026 Consecutive strobes on back-to-back cycles SHALL be accepted without loss.

Reset
REQ-027 rst_n=0 at a rising edge SHALL set state IDLE, bit counter 0, byte counter 0, shift 0x00, XOR 0x00, all outputs 0.
REQ-028 Reset mid-frame SHALL abort without frame_error pulse; first frame after reset needs a new in_insync rise.
REQ-029 Reset SHALL take priority over every other input.

Verification
REQ-030 insync rise, sync bit, L=0x02, payload 0xA5 0x3C, checksum 0x99 -> frame_start with frame_len=2, byte_valid twice (0xA5, 0x3C), frame_end once, frame_error never.
REQ-031 Same frame with checksum 0x98 -> two byte_valid pulses, frame_error once, frame_end never, then strobes ignored until in_insync=0.
REQ-032 L=0x00 and, separately, L=MAX_LEN+1 -> frame_error once, no frame_start, no byte_valid.
REQ-033 in_insync drops after 3 bits of 2nd payload byte -> frame_error once, busy=0 next cycle; new frame after re-sync decodes correctly.
REQ-034 rst_n=0 for one cycle during PAYLOAD -> all outputs 0, no pulses, state IDLE.
REQ-035 Strobes on every cycle for a full L=1 frame (payload 0xFF, checksum 0xFF) -> byte_valid with 0xFF, frame_end once.
